// File: rtl/sram_dp_param.sv
// Parametrised simple-dual-port synchronous SRAM with post-reset clear sequencer.
// Optional macro SRAM_BYPASS_EN selects write-first behaviour on same-address read/write.
module sram_dp_param #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 4,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              wr_done,
    output logic              rd_done,
    output logic              busy
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                rd_acc, wr_acc;
    logic [DATA_W-1:0]   rd_word;

    logic [DATA_W-1:0]   rd_data_p1;
    logic                rd_vld_p1;
    logic                wr_vld_p1;
    logic                busy_p1;

    always_comb begin
        state_next = state;
        rd_acc     = 1'b0;
        wr_acc     = 1'b0;
        case (state)
            CLEAR: begin
                if (cnt == '1) state_next = RUN;
            end
            RUN: begin
                rd_acc = read;
                wr_acc = write;
            end
            default: state_next = CLEAR;
        endcase
    end

`ifdef SRAM_BYPASS_EN
    assign rd_word = (write && (write_addr == read_addr)) ? wr_data : mem[read_addr];
`else
    assign rd_word = mem[read_addr];
`endif

    // Stage p1: state, clear counter, registered read data and done flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            cnt        <= '0;
            busy_p1    <= 1'b1;
            rd_vld_p1  <= 1'b0;
            wr_vld_p1  <= 1'b0;
            rd_data_p1 <= '0;
        end else begin
            state     <= state_next;
            if (state == CLEAR) cnt <= cnt + ADDR_W'(1);
            busy_p1   <= (state_next == CLEAR);
            rd_vld_p1 <= rd_acc;
            wr_vld_p1 <= wr_acc;
            if (rd_acc) rd_data_p1 <= rd_word;
        end
    end

    // Storage array: clear sequencer owns the write port until RUN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) mem[cnt] <= INIT_VAL;
            else if (wr_acc)    mem[write_addr] <= wr_data;
        end
    end

    assign rd_data = rd_data_p1;
    assign rd_done = rd_vld_p1;
    assign wr_done = wr_vld_p1;
    assign busy    = busy_p1;

endmodule

// File: tb/tb_sram_dp_param.sv
// Self-checking bench for sram_dp_param: directed vector table, multi-cycle
// reset/clear sequences and randomized traffic against a behavioural memory model.
module tb_sram_dp_param;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam logic [7:0] INIT = 8'h00;
`ifdef SRAM_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       read, write;
    logic [7:0] wr_data;
    logic [3:0] write_addr, read_addr;
    logic [7:0] rd_data;
    logic       wr_done, rd_done, busy;

    int checks   = 0;
    int failures = 0;

    sram_dp_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .INIT_VAL(INIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .read      (read),
        .write     (write),
        .wr_data   (wr_data),
        .write_addr(write_addr),
        .read_addr (read_addr),
        .rd_data   (rd_data),
        .wr_done   (wr_done),
        .rd_done   (rd_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rd;
        logic       wr;
        logic [3:0] waddr;
        logic [3:0] raddr;
        logic [7:0] wdata;
        logic [7:0] exp_data;
        logic       exp_rdone;
        logic       exp_wdone;
    } vec_t;

    vec_t vecs[$];

    // behavioural reference state
    logic [7:0] model_mem [16];
    logic [7:0] model_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        read = 1'b0; write = 1'b0; wr_data = 8'h00; write_addr = 4'd0; read_addr = 4'd0;
    endtask

    task automatic add(input logic rd, input logic wr, input logic [3:0] wa, input logic [3:0] ra,
                       input logic [7:0] wd, input logic [7:0] ed, input logic erd, input logic ewd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.waddr = wa; v.raddr = ra; v.wdata = wd;
        v.exp_data = ed; v.exp_rdone = erd; v.exp_wdone = ewd;
        vecs.push_back(v);
    endtask

    // Deassert reset and count cycles with busy high, while hammering requests that must be ignored.
    task automatic run_clear(input string tag);
        int n;
        n = 0;
        rst = 1'b0;
        read = 1'b1; write = 1'b1; wr_data = 8'hFF; write_addr = 4'd2; read_addr = 4'd2;
        while (busy === 1'b1 && n < 40) begin
            step();
            n++;
            check({tag, "_busy_wr_done"}, wr_done, 0);
            check({tag, "_busy_rd_done"}, rd_done, 0);
        end
        idle_inputs();
        check({tag, "_busy_edges"}, n, 16);
    endtask

    initial begin
        logic [7:0] coll;
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        check("reset_busy", busy, 1);
        check("reset_rd_data", rd_data, 0);
        check("reset_rd_done", rd_done, 0);
        check("reset_wr_done", wr_done, 0);

        run_clear("clear1");

        coll = BYPASS ? 8'h22 : 8'h11;
        //  rd    wr    wa     ra     wdata  exp    rdone wdone
        add(1'b1, 1'b0, 4'd0, 4'd5, 8'h00, 8'h00, 1'b1, 1'b0);
        add(1'b0, 1'b1, 4'd3, 4'd0, 8'h5A, 8'h00, 1'b0, 1'b1);
        add(1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd3, 8'h00, 8'h5A, 1'b1, 1'b0);
        add(1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 8'h5A, 1'b0, 1'b0);
        add(1'b0, 1'b0, 4'd0, 4'd1, 8'h00, 8'h5A, 1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd3, 4'd0, 8'h4B, 8'h5A, 1'b0, 1'b1);
        add(1'b1, 1'b0, 4'd0, 4'd3, 8'h00, 8'h4B, 1'b1, 1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd4, 8'h00, 8'h00, 1'b1, 1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00, 1'b1, 1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd1, 8'h00, 8'h00, 1'b1, 1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd2, 8'h00, 8'h00, 1'b1, 1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd3, 8'h00, 8'h4B, 1'b1, 1'b0);
        add(1'b0, 1'b1, 4'd7, 4'd0, 8'h11, 8'h4B, 1'b0, 1'b1);
        add(1'b1, 1'b1, 4'd7, 4'd7, 8'h22, coll,  1'b1, 1'b1);
        add(1'b1, 1'b0, 4'd0, 4'd7, 8'h00, 8'h22, 1'b1, 1'b0);
        add(1'b1, 1'b1, 4'd5, 4'd6, 8'h77, 8'h00, 1'b1, 1'b1);
        add(1'b1, 1'b0, 4'd0, 4'd5, 8'h00, 8'h77, 1'b1, 1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd2, 8'h00, 8'h00, 1'b1, 1'b0);

        foreach (vecs[i]) begin
            read = vecs[i].rd; write = vecs[i].wr;
            write_addr = vecs[i].waddr; read_addr = vecs[i].raddr; wr_data = vecs[i].wdata;
            step();
            check($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].exp_data);
            check($sformatf("vec%0d_rd_done", i), rd_done, vecs[i].exp_rdone);
            check($sformatf("vec%0d_wr_done", i), wr_done, vecs[i].exp_wdone);
            check($sformatf("vec%0d_busy", i), busy, 0);
        end
        idle_inputs();

        // reset arriving together with a read, right after a write
        write = 1'b1; write_addr = 4'd9; wr_data = 8'hAA;
        step();
        check("midrun_wr_done", wr_done, 1);
        idle_inputs();
        rst = 1'b1; read = 1'b1; read_addr = 4'd9;
        step();
        check("midrun_rd_done", rd_done, 0);
        check("midrun_rd_data", rd_data, 0);
        check("midrun_busy", busy, 1);
        run_clear("clear2");
        read = 1'b1; read_addr = 4'd9;
        step();
        check("midrun_addr9", rd_data, INIT);
        check("midrun_addr9_done", rd_done, 1);
        idle_inputs();

        // randomized traffic against the reference model
        for (int a = 0; a < 16; a++) model_mem[a] = INIT;
        model_rd = rd_data;
        for (int c = 0; c < 400; c++) begin
            logic       r, w;
            logic [3:0] wa, ra;
            logic [7:0] wd;
            r  = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            wa = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            wd = 8'($urandom_range(0, 255));
            read = r; write = w; write_addr = wa; read_addr = ra; wr_data = wd;
            if (r) model_rd = (BYPASS && w && wa == ra) ? wd : model_mem[ra];
            if (w) model_mem[wa] = wd;
            step();
            check($sformatf("rand%0d_rd_data", c), rd_data, model_rd);
            check($sformatf("rand%0d_rd_done", c), rd_done, r);
            check($sformatf("rand%0d_wr_done", c), wr_done, w);
        end
        idle_inputs();

        // final sweep: every word must match the model
        for (int a = 0; a < 16; a++) begin
            read = 1'b1; read_addr = 4'(a);
            step();
            check($sformatf("sweep%0d", a), rd_data, model_mem[a]);
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_dp_param.md
# sram_dp_param

Parametrised simple-dual-port synchronous SRAM, successor to the fixed 16x4 memory. Adds configurable data width and depth, independent read and write ports usable in the same cycle, and a self-clearing initialisation sequencer after reset with a `busy` flag. An optional compile-time read-during-write bypass is provided. Sits as the generic on-chip buffer under the team's datapath and FIFO blocks.

## Interface
- `DATA_W`, default 8: data width in bits, 1 or more.
- `ADDR_W`, default 4: address width. Depth is `2**ADDR_W`, so every address is in range.
- `INIT_VAL`, default 0: the `DATA_W`-bit value written to every word by the clear sequence.

- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `read` input, 1 bit: read request, sampled at `clk` rising edge.
- `write` input, 1 bit: write request, sampled at `clk` rising edge.
- `wr_data` input, `DATA_W` bits: write data.
- `write_addr` input, `ADDR_W` bits: write address.
- `read_addr` input, `ADDR_W` bits: read address.
- `rd_data` output, `DATA_W` bits: registered read data.
- `wr_done` output, 1 bit: one-cycle pulse marking an accepted write.
- `rd_done` output, 1 bit: one-cycle pulse marking valid `rd_data`.
- `busy` output, 1 bit: high while the clear sequence runs; requests are ignored.

## Operation
- **FSM states:** CLEAR and RUN.
- **Reset:** any edge with `rst`=1 moves the FSM to CLEAR and sets the clear counter to 0. It also sets `rd_data`=0, `wr_done`=0, `rd_done`=0 and `busy`=1.
- **CLEAR:**
  - Each edge with `rst`=0 writes `INIT_VAL` to `mem[cnt]` and increments `cnt`.
  - The edge that writes address `2**ADDR_W-1` moves the FSM to RUN and clears `busy`.
  - In CLEAR, `read` and `write` are ignored: no memory change, no done pulses, `rd_data` holds.
- **RUN, write:** `write`=1 at an edge stores `wr_data` into `mem[write_addr]`. `wr_done` is 1 for the cycle after that edge.
- **RUN, read:** `read`=1 at an edge loads `rd_data` with `mem[read_addr]`. `rd_done` is 1 for the cycle after that edge.
- **Holding outputs:** `rd_data` holds its last value until the next accepted read.
- **Back-to-back:** holding `read` and/or `write` high accepts one operation per port per cycle. The matching done flag stays high for every cycle that follows an accepting edge.
- **Simultaneous read and write, different addresses:** both ports operate independently.
- **Simultaneous read and write, same address:** the result depends on `SRAM_BYPASS_EN` (see Configuration). The write always takes effect.
- **Reset mid-operation:** a pending done pulse is cancelled, and the full clear sequence restarts from address 0. This applies whether reset arrives during CLEAR or during RUN.

## Timing
- Write latency: data is stored at the accepting edge, and `wr_done` is high in the following cycle.
- Read latency: 1 cycle. `rd_data` and `rd_done` are valid together, in the cycle after the accepting edge.
- Clear duration: `busy` falls exactly `2**ADDR_W` edges after the first edge with `rst`=0. With `ADDR_W`=4 that is 16 edges.
- The first request accepted is one presented at an edge where `busy` was already 0.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- Macro: `SRAM_BYPASS_EN`.
- **Defined (write-first):** a same-address read and write at one edge returns the new `wr_data` on `rd_data`.
- **Undefined (read-first):** the same collision returns the old memory contents.
- In both cases `rd_done` pulses and the memory holds the new value afterwards.

## Test plan
1. **Reset and clear:** `DATA_W`=8, `ADDR_W`=4, pulse `rst` for 2 cycles. Expect `busy`=1 for 16 edges, then 0. Then read address 5: expect `rd_data`=0x00 and `rd_done`=1 one cycle later.
2. **Basic write/read:**
   - Write 0x5A to address 3: `wr_done`=1 for exactly 1 cycle.
   - Read address 3: `rd_data`=0x5A with `rd_done`.
   - `rd_data` holds 0x5A while `read`=0.
3. **Overwrite and streaming:**
   - Write 0x4B to address 3, then read address 3: expect 0x4B.
   - Read address 4: expect 0x00.
   - Hold `read`=1 over addresses 0..3: expect 4 consecutive `rd_done` cycles with the matching data.
4. **Collision:** `mem[7]`=0x11, then `read` and `write` to address 7 with 0x22 in the same cycle.
   - Expect `rd_data`=0x22 with `SRAM_BYPASS_EN`, 0x11 without.
   - A following read of address 7 returns 0x22 in both builds.
5. **Request during busy:** assert `write` with 0xFF to address 2 while `busy`=1. Expect no `wr_done`. After clear, address 2 reads 0x00.
6. **Reset mid-run:**
   - Write 0xAA to address 9, then assert `rst` in the same cycle as a read request.
   - Expect no `rd_done`, `rd_data`=0, and a full 16-cycle `busy` period.
   - Address 9 then reads `INIT_VAL`.
